// File: rtl/piso_sequencer_8_if.sv
// Handshake/data bundle between the word source and the PISO sequencer.
// Names are from the sequencer's point of view: i_* flow into it, o_* flow out of it.
interface piso_sequencer_8_if;
  logic [7:0] i_din;
  logic       i_load;
  logic       i_abort;
  logic [7:0] o_q;
  logic [2:0] o_s;
  logic       o_sd;
  logic       o_valid;
  logic       o_last;
  logic       o_busy;
  logic       o_done;

  modport master (
    output i_din, i_load, i_abort,
    input  o_q, o_s, o_sd, o_valid, o_last, o_busy, o_done
  );

  modport slave (
    input  i_din, i_load, i_abort,
    output o_q, o_s, o_sd, o_valid, o_last, o_busy, o_done
  );
endinterface

// File: rtl/piso_sequencer_8.sv
// Parallel-in/serial-out sequencer feeding a 1-bit 8x1 mux.
// Captures a word into q, then walks the mux select s across all eight
// inputs, holding each position for BIT_CYCLES clocks.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for a load; all registers hold
// ST_SHIFT | presenting bit q[s]; tick counts clocks spent on this bit
// ST_DONE  | one-cycle completion pulse; a load here starts the next word
module piso_sequencer_8 #(
  parameter bit          MSB_FIRST  = 1'b0,
  parameter int unsigned BIT_CYCLES = 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  piso_sequencer_8_if.slave   io_bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [2:0] LP_S_FIRST = MSB_FIRST ? 3'd7 : 3'd0;
  localparam logic [2:0] LP_S_FINAL = MSB_FIRST ? 3'd0 : 3'd7;
  localparam logic [3:0] LP_TICK_TC = 4'(BIT_CYCLES - 1);

  state_t     r_state, w_state_nxt;
  logic [7:0] r_q, w_q_nxt;
  logic [2:0] r_s, w_s_nxt;
  logic [3:0] r_tick, w_tick_nxt;

  logic       w_valid;
  logic       w_tick_tc;
  logic       w_s_final;

  assign w_tick_tc = (r_tick == LP_TICK_TC);
  assign w_s_final = (r_s == LP_S_FINAL);

  // State, word, select and tick registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_q     <= 8'h00;
      r_s     <= 3'b000;
      r_tick  <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_s     <= w_s_nxt;
      r_tick  <= w_tick_nxt;
    end
  end

  // Next-state logic: capture on load in IDLE/DONE, bit stepping in SHIFT.
  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_s_nxt     = r_s;
    w_tick_nxt  = r_tick;
    unique case (r_state)
      ST_IDLE: begin
        if (io_bus.i_load) begin
          w_q_nxt     = io_bus.i_din;
          w_s_nxt     = LP_S_FIRST;
          w_tick_nxt  = 4'd0;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // Abort leaves q and s frozen so the mux keeps its last selection.
        if (io_bus.i_abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_tick_tc) begin
          w_tick_nxt = 4'd0;
          if (w_s_final) begin
            w_state_nxt = ST_DONE;
          end else if (MSB_FIRST) begin
            w_s_nxt = r_s - 3'd1;
          end else begin
            w_s_nxt = r_s + 3'd1;
          end
        end else begin
          w_tick_nxt = r_tick + 4'd1;
        end
      end
      ST_DONE: begin
        // Load takes precedence over abort here; abort has nothing to cancel.
        if (io_bus.i_load) begin
          w_q_nxt     = io_bus.i_din;
          w_s_nxt     = LP_S_FIRST;
          w_tick_nxt  = 4'd0;
          w_state_nxt = ST_SHIFT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded from registered state only; sd mirrors the external mux.
  assign w_valid        = (r_state == ST_SHIFT);
  assign io_bus.o_q     = r_q;
  assign io_bus.o_s     = r_s;
  assign io_bus.o_sd    = w_valid ? r_q[r_s] : 1'b0;
  assign io_bus.o_valid = w_valid;
  assign io_bus.o_last  = w_valid && w_s_final;
  assign io_bus.o_busy  = (r_state == ST_SHIFT) || (r_state == ST_DONE);
  assign io_bus.o_done  = (r_state == ST_DONE);

endmodule

// File: tb/tb_piso_sequencer_8.sv
// Directed bench for piso_sequencer_8: one LSB-first instance with one clock
// per bit, one MSB-first instance with three clocks per bit.
module tb_piso_sequencer_8;

  logic clk;
  logic rst;

  int n_checks;
  int n_errors;

  piso_sequencer_8_if if_a ();
  piso_sequencer_8_if if_b ();

  piso_sequencer_8 #(.MSB_FIRST(1'b0), .BIT_CYCLES(1)) u_dut_a (
    .i_clk (clk),
    .i_rst (rst),
    .io_bus(if_a.slave)
  );

  piso_sequencer_8 #(.MSB_FIRST(1'b1), .BIT_CYCLES(3)) u_dut_b (
    .i_clk (clk),
    .i_rst (rst),
    .io_bus(if_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks every instance-A output against its reset value.
  task automatic chk_a_reset(input string tag);
    chk({tag, " q"},     32'(if_a.o_q),     32'h00);
    chk({tag, " s"},     32'(if_a.o_s),     32'd0);
    chk({tag, " sd"},    32'(if_a.o_sd),    32'd0);
    chk({tag, " valid"}, 32'(if_a.o_valid), 32'd0);
    chk({tag, " last"},  32'(if_a.o_last),  32'd0);
    chk({tag, " busy"},  32'(if_a.o_busy),  32'd0);
    chk({tag, " done"},  32'(if_a.o_done),  32'd0);
  endtask

  // Instance A, sampled at the negedge while bit k of word w is presented.
  task automatic chk_a_bit(input string tag, input int k, input logic [7:0] w);
    logic [7:0] word;
    word = w;
    chk($sformatf("%s s[%0d]", tag, k),     32'(if_a.o_s),     32'(k));
    chk($sformatf("%s sd[%0d]", tag, k),    32'(if_a.o_sd),    32'(word[k]));
    chk($sformatf("%s valid[%0d]", tag, k), 32'(if_a.o_valid), 32'd1);
    chk($sformatf("%s busy[%0d]", tag, k),  32'(if_a.o_busy),  32'd1);
    chk($sformatf("%s last[%0d]", tag, k),  32'(if_a.o_last),  32'(k == 7));
    chk($sformatf("%s done[%0d]", tag, k),  32'(if_a.o_done),  32'd0);
  endtask

  task automatic chk_a_done(input string tag);
    chk({tag, " done"},  32'(if_a.o_done),  32'd1);
    chk({tag, " valid"}, 32'(if_a.o_valid), 32'd0);
    chk({tag, " busy"},  32'(if_a.o_busy),  32'd1);
    chk({tag, " sd"},    32'(if_a.o_sd),    32'd0);
    chk({tag, " last"},  32'(if_a.o_last),  32'd0);
  endtask

  task automatic chk_a_idle(input string tag);
    chk({tag, " done"},  32'(if_a.o_done),  32'd0);
    chk({tag, " valid"}, 32'(if_a.o_valid), 32'd0);
    chk({tag, " busy"},  32'(if_a.o_busy),  32'd0);
  endtask

  initial begin
    logic [7:0] w;
    int idx;
    n_checks = 0;
    n_errors = 0;

    rst = 1'b0;
    if_a.i_din = 8'h00; if_a.i_load = 1'b0; if_a.i_abort = 1'b0;
    if_b.i_din = 8'h00; if_b.i_load = 1'b0; if_b.i_abort = 1'b0;

    // Reset held two cycles while load is requested with 8'hFF.
    @(negedge clk);
    rst = 1'b1;
    if_a.i_din = 8'hFF; if_a.i_load = 1'b1;
    if_b.i_din = 8'hFF; if_b.i_load = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_a_reset("rst");
    chk("rst b q",    32'(if_b.o_q),     32'h00);
    chk("rst b s",    32'(if_b.o_s),     32'd0);
    chk("rst b last", 32'(if_b.o_last),  32'd0);
    chk("rst b valid",32'(if_b.o_valid), 32'd0);
    chk("rst b done", 32'(if_b.o_done),  32'd0);
    rst = 1'b0;
    if_a.i_load = 1'b0;
    if_b.i_load = 1'b0;
    @(negedge clk);
    chk_a_reset("idle");

    // LSB-first, one clock per bit: 8'hA5.
    if_a.i_din = 8'hA5; if_a.i_load = 1'b1;
    @(negedge clk);
    if_a.i_load = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk_a_bit("lsb", k, 8'hA5);
      @(negedge clk);
    end
    chk_a_done("lsb end");
    @(negedge clk);
    chk_a_idle("lsb idle");
    chk("lsb q", 32'(if_a.o_q), 32'hA5);
    chk("lsb s hold", 32'(if_a.o_s), 32'd7);

    // MSB-first, three clocks per bit: 8'h3C.
    w = 8'h3C;
    if_b.i_din = w; if_b.i_load = 1'b1;
    @(negedge clk);
    if_b.i_load = 1'b0;
    for (int k = 0; k < 8; k++) begin
      idx = 7 - k;
      for (int c = 0; c < 3; c++) begin
        chk($sformatf("msb s[%0d.%0d]", k, c),     32'(if_b.o_s),     32'(idx));
        chk($sformatf("msb sd[%0d.%0d]", k, c),    32'(if_b.o_sd),    32'(w[idx]));
        chk($sformatf("msb valid[%0d.%0d]", k, c), 32'(if_b.o_valid), 32'd1);
        chk($sformatf("msb last[%0d.%0d]", k, c),  32'(if_b.o_last),  32'(k == 7));
        chk($sformatf("msb done[%0d.%0d]", k, c),  32'(if_b.o_done),  32'd0);
        @(negedge clk);
      end
    end
    chk("msb done",  32'(if_b.o_done),  32'd1);
    chk("msb valid", 32'(if_b.o_valid), 32'd0);
    chk("msb busy",  32'(if_b.o_busy),  32'd1);
    @(negedge clk);
    chk("msb idle done", 32'(if_b.o_done), 32'd0);
    chk("msb idle busy", 32'(if_b.o_busy), 32'd0);
    chk("msb q",         32'(if_b.o_q),    32'h3C);

    // Back-to-back: 8'h0F then 8'hF0 loaded in the DONE cycle.
    if_a.i_din = 8'h0F; if_a.i_load = 1'b1;
    @(negedge clk);
    if_a.i_load = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk_a_bit("b2b0", k, 8'h0F);
      @(negedge clk);
    end
    chk_a_done("b2b gap");
    if_a.i_din = 8'hF0; if_a.i_load = 1'b1;
    @(negedge clk);
    if_a.i_load = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk_a_bit("b2b1", k, 8'hF0);
      @(negedge clk);
    end
    chk_a_done("b2b1 end");
    @(negedge clk);
    chk_a_idle("b2b idle");

    // Load attempted mid-word is ignored.
    if_a.i_din = 8'h81; if_a.i_load = 1'b1;
    @(negedge clk);
    if_a.i_load = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk_a_bit("midld", k, 8'h81);
      chk($sformatf("midld q[%0d]", k), 32'(if_a.o_q), 32'h81);
      if (k == 3) begin
        if_a.i_din = 8'h7E; if_a.i_load = 1'b1;
      end else begin
        if_a.i_load = 1'b0;
      end
      @(negedge clk);
    end
    chk_a_done("midld end");
    chk("midld q end", 32'(if_a.o_q), 32'h81);
    @(negedge clk);
    chk_a_idle("midld idle");

    // Abort at s=4.
    if_a.i_din = 8'hC3; if_a.i_load = 1'b1;
    @(negedge clk);
    if_a.i_load = 1'b0;
    for (int k = 0; k < 4; k++) @(negedge clk);
    chk_a_bit("abort pre", 4, 8'hC3);
    if_a.i_abort = 1'b1;
    @(negedge clk);
    if_a.i_abort = 1'b0;
    chk_a_idle("abort");
    chk("abort s",  32'(if_a.o_s),  32'd4);
    chk("abort q",  32'(if_a.o_q),  32'hC3);
    chk("abort sd", 32'(if_a.o_sd), 32'd0);
    chk("abort last", 32'(if_a.o_last), 32'd0);
    @(negedge clk);
    chk_a_idle("abort after");
    chk("abort after s", 32'(if_a.o_s), 32'd4);

    // Synchronous reset at s=4.
    if_a.i_din = 8'h5A; if_a.i_load = 1'b1;
    @(negedge clk);
    if_a.i_load = 1'b0;
    for (int k = 0; k < 4; k++) @(negedge clk);
    chk_a_bit("rstmid pre", 4, 8'h5A);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_a_reset("rstmid");
    @(negedge clk);
    chk_a_reset("rstmid after");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/piso_sequencer_8.md
# piso_sequencer_8

Parallel-in/serial-out sequencer that sits directly upstream of the 1-bit 8x1 mux in the datapath. It captures an 8-bit word on a load request and holds it on `q[7:0]`, which drives mux inputs i0..i7. It then steps the 3-bit select `s` through all eight positions, holding each for a programmable number of clocks. It also provides the serial bit, per-bit valid/last flags and a completion pulse for downstream consumers.

## Interface
- `MSB_FIRST`, default 0: 0 steps `s` 0→7; 1 steps `s` 7→0.
- `BIT_CYCLES`, default 1: clocks each select value is held; legal range 1..16.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `din`  in  8: parallel word, sampled when a load is accepted.
- `load`  in  1: load request; accepted only in IDLE or DONE.
- `abort`  in  1: cancels an in-progress word.
- `q`  out  8: captured word; bit n drives mux input i`n`.
- `s`  out  3: select to the 8x1 mux; registered.
- `sd`  out  1: serial bit, equal to `q[s]` when `valid`=1, else 0. Combinational from registers.
- `valid`  out  1: high while in SHIFT.
- `last`  out  1: high for all cycles of the eighth bit.
- `busy`  out  1: high in SHIFT and DONE.
- `done`  out  1: one-cycle pulse after the eighth bit completes.

## Operation
- States: IDLE, SHIFT, DONE. There is a 3-bit bit index (drives `s`), a 4-bit tick counter and the 8-bit word register `q`.
- IDLE:
  - `load`=1 → `q`←`din`, `s`←(MSB_FIRST ? 7 : 0), tick←0, next state SHIFT.
  - `load`=0 → all registers hold.
- SHIFT:
  - If tick = BIT_CYCLES−1 and the bit is not the eighth, tick←0 and `s` steps +1 (or −1 when MSB_FIRST). Otherwise tick increments.
  - If tick = BIT_CYCLES−1 on the eighth bit, next state is DONE.
  - `last`=1 whenever `s` is the final index: 7, or 0 when MSB_FIRST.
- DONE: lasts one cycle with `done`=1 and `valid`=0.
  - `load`=1 → same capture as in IDLE, next state SHIFT. This gives back-to-back words.
  - `load`=0 → next state IDLE.
- `load` in SHIFT is ignored; `q` is not modified.
- `abort`=1 in SHIFT → next state IDLE, no `done` pulse, `q` and `s` hold their values.
- `abort` in IDLE or DONE has no effect.
- `abort` and `load` both high in DONE: `load` wins.
- `q` changes only on an accepted load or on reset.
- `s` changes only on a load, a bit advance or reset.
- No wrap-around: `s` never steps past the final index.

## Timing
- Reset values: state IDLE, `q`=8'h00, `s`=3'b000, tick=0, `sd`=0, `valid`=0, `last`=0, `busy`=0, `done`=0.
- `rst` takes priority over `load` and `abort`. A reset asserted mid-SHIFT returns to IDLE on the next edge with no `done` pulse.
- Let `load` be accepted at edge E0:
  - `valid` and `busy` rise after E0.
  - The bit with index k, counted in shift order from 0, is presented from after edge E(k·BIT_CYCLES) until edge E((k+1)·BIT_CYCLES).
  - After E(8·BIT_CYCLES) the block is in DONE: `done`=1 and `valid`=0.
  - After E(8·BIT_CYCLES+1) the block is in IDLE, or in SHIFT if reloaded.
- Latency from load to first bit: 1 cycle.
- Word period: 8·BIT_CYCLES+1 cycles with back-to-back loads.
- `valid` and `last` are pure functions of the registered state and `s`. `sd` follows `s` and `q` combinationally, matching the output of the attached 8x1 mux.

## Test plan
- Reset: hold `rst` for 2 cycles with `load`=1 and `din`=8'hFF → every output at its reset value; `q` stays 8'h00.
- LSB-first, BIT_CYCLES=1: load 8'hA5 → `s`=0..7 on consecutive cycles; `sd`=1,0,1,0,0,1,0,1; `last` only at `s`=7; `done` 9 cycles after load.
- MSB_FIRST=1, BIT_CYCLES=3: load 8'h3C → each `s` value 7..0 held exactly 3 cycles; `sd`=0,0,1,1,1,1,0,0; `done` 25 cycles after load.
- Back-to-back, BIT_CYCLES=1: load 8'h0F, then load 8'hF0 during the DONE cycle → `valid` low for exactly 1 cycle between the words; second word serializes 0,0,0,0,1,1,1,1.
- Load during SHIFT: load 8'h81 at mid-word, then load 8'h7E → `q` stays 8'h81 and the serial stream is unchanged.
- Interrupts, both with the block in SHIFT at `s`=4:
  - `abort` → IDLE next cycle, no `done`, `q` and `s` hold.
  - `rst` instead of `abort` → all outputs return to their reset values.
